// File: rtl/echo_measure_sequencer_pkg.sv
// echo_measure_sequencer_pkg: shared state encoding and result constants for the echo measurement sequencer
package echo_measure_sequencer_pkg;
  localparam int DIST_W = 16;
  localparam logic [DIST_W-1:0] DIST_TIMEOUT = 16'hFFFF;
  typedef enum logic [2:0] {IDLE, TRIG, BLANK, ARM, MEASURE, CAPTURE, HOLDOFF} state_t;
endpackage

// File: rtl/echo_measure_sequencer_echo_sync.sv
// echo_sync_edge: two-flop synchronizer for the raw echo plus rise/fall detection on the synchronized level
module echo_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic echo_in,
  output logic rise,
  output logic fall
);
  logic [1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[0], echo_in};
    prev_d = sync_q[1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  assign rise = sync_q[1] & ~prev_q;
  assign fall = ~sync_q[1] & prev_q;
endmodule

// File: rtl/echo_measure_sequencer.sv
// echo_measure_sequencer: fires the trigger, blanks ringing, gates echo_counter around the echo
// and reports a captured distance or a timeout, single-shot or at a fixed repetition period.
module echo_measure_sequencer
  import echo_measure_sequencer_pkg::*;
#(
  parameter int TRIG_CYCLES    = 200,
  parameter int BLANK_CYCLES   = 2000,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int PERIOD_CYCLES  = 1200000,
  parameter int CNT_W          = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              echo_in,
  input  logic [DIST_W-1:0] distance_raw,
  output logic              trig_out,
  output logic              enable_count,
  output logic              count_clear,
  output logic [DIST_W-1:0] distance,
  output logic              result_valid,
  output logic              timeout,
  output logic              busy
);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d, per_q, per_d;
  logic [DIST_W-1:0] distance_q, distance_d;
  logic timeout_q, timeout_d, valid_q, valid_d;
  logic echo_rise, echo_fall;
  echo_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (reset),
    .echo_in(echo_in),
    .rise   (echo_rise),
    .fall   (echo_fall)
  );
  // tmr_q is reused per state: pulse width, blanking, timeout (ARM+MEASURE) and capture settle
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + 1'b1;
    per_d       = (per_q >= PER_LAST) ? per_q : per_q + 1'b1;
    distance_d  = distance_q;
    timeout_d   = timeout_q;
    valid_d     = 1'b0;
    count_clear = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        per_d = '0;
        if (start || continuous) begin
          state_d     = TRIG;
          count_clear = 1'b1;
          timeout_d   = 1'b0;
        end
      end
      TRIG: if (tmr_q == TRIG_LAST) begin
        state_d = BLANK;
        tmr_d   = '0;
      end
      BLANK: if (tmr_q == BLANK_LAST) begin
        state_d = ARM;
        tmr_d   = '0;
      end
      ARM, MEASURE: begin
        if (tmr_q == TMO_LAST) begin
          state_d    = HOLDOFF;
          distance_d = DIST_TIMEOUT;
          timeout_d  = 1'b1;
          valid_d    = 1'b1;
        end else if (state_q == ARM && echo_rise) begin
          state_d = MEASURE;
        end else if (state_q == MEASURE && echo_fall) begin
          state_d = CAPTURE;
          tmr_d   = '0;
        end
      end
      CAPTURE: if (tmr_q == CNT_W'(1)) begin
        state_d    = HOLDOFF;
        distance_d = distance_raw;
        timeout_d  = 1'b0;
        valid_d    = 1'b1;
      end
      HOLDOFF: if (per_q >= PER_LAST) begin
        state_d     = continuous ? TRIG : IDLE;
        count_clear = continuous;
        per_d       = '0;
        tmr_d       = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      per_q      <= '0;
      distance_q <= '0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      per_q      <= per_d;
      distance_q <= distance_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
    end
  assign trig_out     = state_q == TRIG;
  assign enable_count = state_q == MEASURE;
  assign busy         = state_q != IDLE;
  assign distance     = distance_q;
  assign timeout      = timeout_q;
  assign result_valid = valid_q;
endmodule

// File: doc/echo_measure_sequencer.md
Name: echo_measure_sequencer

Overview:
Per-sensor measurement controller for the ultrasonic parking sensor. It fires the transducer trigger pulse and masks the ringing with a blanking window. It then gates enable_count of echo_counter around the synchronized echo, captures distance_raw, and reports a result or a timeout. It runs single-shot or at a fixed repetition period, and sits between the system/CSR logic and echo_counter.

Parameters:
TRIG_CYCLES, 200, trigger pulse width in clk cycles (10 us at 20 MHz)
BLANK_CYCLES, 2000, ringing mask after trigger falls; echo ignored
TIMEOUT_CYCLES, 60000, max cycles from ARM entry to echo fall
PERIOD_CYCLES, 1200000, trigger-to-trigger interval in continuous mode (60 ms)
CNT_W, 24, width of internal timers; must hold max(PERIOD_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock (20 MHz)
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request for one measurement; ignored unless IDLE
continuous  input  1  level: repeat measurements every PERIOD_CYCLES while high
echo_in  input  1  raw echo from receiver front end (asynchronous)
distance_raw  input  16  count from echo_counter
trig_out  output  1  transducer trigger pulse
enable_count  output  1  gate to echo_counter
count_clear  output  1  one-cycle clear to echo_counter, ORed into its reset by the integrator
distance  output  16  last captured result
result_valid  output  1  one-cycle strobe when distance/timeout update
timeout  output  1  sticky until next result: last measurement timed out
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-low): state IDLE. All outputs 0, distance=16'h0000, timers 0, echo synchronizer flops 0.
- echo_in passes through a 2-flop synchronizer (echo_s). The edge detector compares echo_s with its previous value. Latency is 2-3 cycles.
- IDLE: when start=1 or continuous=1, go to TRIG. Pulse count_clear in the same cycle, reset the period timer to 0, and clear the timeout flag.
- TRIG: trig_out=1 for exactly TRIG_CYCLES cycles, then go to BLANK.
- BLANK: BLANK_CYCLES cycles. Echo edges are ignored. Then go to ARM and reset the timeout timer.
- ARM: wait for a rising edge of echo_s. On the edge, go to MEASURE with enable_count=1 from the next cycle. An echo already high at ARM entry does not count; a fresh rising edge is required.
- MEASURE: enable_count=1. On a falling edge of echo_s, go to CAPTURE and drop enable_count.
- Timeout: the timer runs through ARM and MEASURE. When it reaches TIMEOUT_CYCLES-1, drop enable_count. Then load distance=16'hFFFF, set timeout=1, pulse result_valid, and go to HOLDOFF.
- CAPTURE: 2 cycles, to let echo_counter settle. At the end, load distance=distance_raw, timeout=0, pulse result_valid, and go to HOLDOFF.
- HOLDOFF: wait until the period timer (started at TRIG entry) reaches PERIOD_CYCLES-1.
  - If continuous=1 at that cycle: go to TRIG and pulse count_clear.
  - Otherwise: go to IDLE.
  - Single-shot measurements also honour PERIOD_CYCLES. This guarantees acoustic decay before any retrigger.
- start while busy: ignored, not queued.
- Dropping continuous mid-measurement: the current measurement completes and reports. The block returns to IDLE at the end of HOLDOFF.
- The period timer saturates and does not wrap. If TIMEOUT path + TRIG + BLANK exceeds PERIOD_CYCLES, HOLDOFF lasts one cycle.
- result_valid is exactly one cycle per measurement. distance is held between results.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, TRIG, BLANK, ARM, MEASURE, CAPTURE, HOLDOFF)
  - DIST_W=16
  - DIST_TIMEOUT=16'hFFFF
- One natural sub-module: echo_sync_edge (2-flop synchronizer plus rise/fall detector, async active-low reset). It is reused by future multi-sensor scheduling.
- Timers stay inline.

Test Plan:
All scenarios use TRIG=4, BLANK=10, TIMEOUT=200, PERIOD=400, 50 ns clk.
1. Reset held low mid-MEASURE -> all outputs 0 immediately (asynchronous), distance=0. After release the block stays IDLE with busy=0.
2. Single start, echo high 100 cycles after ARM entry for 50 cycles, model counter fed -> trig_out high exactly 4 cycles; enable_count high about 50 cycles; one result_valid; distance equals model count; timeout=0; busy low at cycle 400 after start.
3. start with no echo -> result_valid at 200 cycles after ARM entry, distance=16'hFFFF, timeout=1.
4. Echo pulse during BLANK only -> ignored; measurement times out. Separately, echo stuck high from BLANK into ARM -> no MEASURE, timeout=1.
5. continuous=1 for 3 periods -> trig_out rising edges exactly 400 cycles apart. Drop continuous mid-second measurement -> that result still reported, then IDLE with no third trigger.
6. start pulses during TRIG, ARM and HOLDOFF -> no extra triggers; result_valid count = 1.
